// File: rtl/mdu_seq.sv
// Iterative MIPS multiply/divide unit: one bit per cycle, produces HI/LO.
// Optional MDU_DIV0_FAST_EN: divide by zero skips the iterations and goes straight to FIX.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem;

  // request decode and operand magnitudes
  logic             start_mdu, op_div, op_signed, sa, sb;
  logic [WIDTH-1:0] amag, bmag;
  assign start_mdu = start && !op[2];
  assign op_div    = op[1];
  assign op_signed = !op[0];
  assign sa        = op_signed && a[WIDTH-1];
  assign sb        = op_signed && b[WIDTH-1];
  assign amag      = sa ? -a : a;
  assign bmag      = sb ? -b : b;
`ifdef MDU_DIV0_FAST_EN
  logic div0;
  assign div0 = op_div && (b == '0);
`endif

  // multiply step: conditional add into the upper half, then shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // divide step: remainder needs one extra bit after the left shift
  logic [WIDTH:0]     trial, diff;
  logic [2*WIDTH-1:0] div_nxt;
  assign trial   = acc[2*WIDTH-1:WIDTH-1];
  assign diff    = trial - {1'b0, m};
  assign div_nxt = diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_mdu) begin
`ifdef MDU_DIV0_FAST_EN
        state_nxt = div0 ? FIX : RUN;
`else
        state_nxt = RUN;
`endif
      end
      RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      m       <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start_mdu) begin
            acc     <= {{WIDTH{1'b0}}, (op_div ? amag : bmag)};
            m       <= op_div ? bmag : amag;
            cnt     <= '0;
            is_div  <= op_div;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
`ifdef MDU_DIV0_FAST_EN
            // same remainder/quotient the full restoring run would leave
            if (div0) acc <= {amag, {WIDTH{1'b1}}};
`endif
          end else if (start && op == 3'b100) begin
            hi <= a;
          end else if (start && op == 3'b101) begin
            lo <= a;
          end
        end
        RUN: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (WIDTH=32): results, latency, busy window, stalls, reset.
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          errors = 0;
  int          checks = 0;

`ifdef MDU_DIV0_FAST_EN
  localparam int LAT0 = 2;
`else
  localparam int LAT0 = 34;
`endif

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge; optionally pulse a second start in cycle inj_cyc.
  // Returns at the negedge of the done cycle, so consecutive calls are back-to-back.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] ia, ib,
                        input logic [31:0] ehi, elo, input int lat, input int inj_cyc,
                        input logic [2:0] inj_op, input logic [31:0] inj_a, inj_b);
    int got = 0, busy_bad = 0, hold_bad = 0;
    logic [31:0] h0 = 32'h0, l0 = 32'h0;
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 60 && got == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin h0 = hi; l0 = lo; end
      if (done) got = n;
      else if (hi !== h0 || lo !== l0) hold_bad++;
      if (busy !== 1'(n < lat)) busy_bad++;
      if (n == inj_cyc) begin start = 1'b1; op = inj_op; a = inj_a; b = inj_b; end
      if (inj_cyc != 0 && n == inj_cyc + 1) start = 1'b0;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(got), 64'(lat));
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " busy window"}, 64'(busy_bad), 64'd0);
    check({tag, " hi/lo hold"}, 64'(hold_bad), 64'd0);
  endtask

  initial begin
    int late_done;
    rst = 1'b1; start = 1'b0; op = 3'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    // MTHI while idle
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h12345678);
    check("mthi lo", 64'(lo), 64'd0);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);

    // reserved op 11x has no effect
    start = 1'b1; op = 3'b110; a = 32'hFFFF0000; b = 32'h3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("op11x hi", 64'(hi), 64'h12345678);
    check("op11x busy", 64'(busy), 64'd0);
    check("op11x done", 64'(done), 64'd0);

    run_op("multu max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 0, 3'b0, 0, 0);
    run_op("mult -3*5", 3'b000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 0, 3'b0, 0, 0);
    run_op("div -7/2", 3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0, 3'b0, 0, 0);
    run_op("div minneg/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 0, 3'b0, 0, 0);
    run_op("divu 7/0", 3'b011, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, LAT0, 0, 3'b0, 0, 0);
    run_op("div -8/0", 3'b010, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'h1, LAT0, 0, 3'b0, 0, 0);
    run_op("div 9/0", 3'b010, 32'h9, 32'h0, 32'h9, 32'hFFFFFFFF, LAT0, 0, 3'b0, 0, 0);
    run_op("divu 100/7 mtlo", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 34, 5, 3'b101, 32'hA5A5A5A5, 0);
    run_op("divu 100/7 multu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 34, 10, 3'b001, 32'd2, 32'd3);
    run_op("mult -6*-7", 3'b000, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'h0, 32'd42, 34, 0, 3'b0, 0, 0);

    @(negedge clk);
    check("done single pulse", 64'(done), 64'd0);

    // reset in cycle 15 of a MULT aborts it
    start = 1'b1; op = 3'b000; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    late_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) late_done++;
    end
    check("abort no done", 64'(late_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
